// File: rtl/data_cache_pkg.sv
// Shared types for the direct-mapped write-back data cache: FSM states,
// memory block geometry and the per-line storage record.
package cache_pkg;

  localparam int BLOCK_BYTES = 4;
  localparam int MEM_ADDR_W  = 6;
  // Widest tag the cache can need (NUM_SETS >= 2 leaves at most 5 tag bits).
  localparam int TAG_MAX_W   = MEM_ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    FETCH,
    REFILL
  } state_t;

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [TAG_MAX_W-1:0]       tag;
    logic [8*BLOCK_BYTES-1:0]   data;
  } line_t;

endpackage

// File: rtl/data_cache_stats.sv
// Saturating hit/miss event counters for the data cache (built only when
// DATA_CACHE_STATS_EN is defined).
module data_cache_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        hit_event,
  input  logic        miss_event,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_event)  hit_count  <= sat_inc(hit_count);
      if (miss_event) miss_count <= sat_inc(miss_count);
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 32-bit
// block memory. Optional statistics counters under DATA_CACHE_STATS_EN.
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = MEM_ADDR_W - IW;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] off);
    return w[8*off +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*off +: 8] = b;
    return r;
  endfunction

  state_t          state, next_state;
  line_t           lines [NUM_SETS];
  line_t           cur, victim;
  logic [IW-1:0]   idx, miss_idx;
  logic [TW-1:0]   tag, miss_tag;
  logic [1:0]      offset;
  logic            req, hit, idle_hit;

  assign offset   = address[1:0];
  assign idx      = address[IW+1:2];
  assign tag      = address[7:IW+2];
  assign cur      = lines[idx];
  assign victim   = lines[miss_idx];
  assign req      = read || write;
  assign hit      = cur.valid && (cur.tag == TAG_MAX_W'(tag));
  assign idle_hit = (state == IDLE) && hit;
  assign busywait = req && !idle_hit;
  // A simultaneous write wins, so the read path stays quiet.
  assign readdata = (idle_hit && read && !write) ? get_byte(cur.data, offset) : 8'h00;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Miss address is captured in IDLE so later CPU changes cannot disturb it.
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      miss_idx <= idx;
      miss_tag <= tag;
    end
  end

  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (req && !hit)
          next_state = (cur.valid && cur.dirty) ? WRITE_BACK : FETCH;
      end
      WRITE_BACK: begin
        mem_write     = 1'b1;
        mem_address   = {victim.tag[TW-1:0], miss_idx};
        mem_writedata = victim.data;
        if (!mem_busywait) next_state = FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = {miss_tag, miss_idx};
        if (!mem_busywait) next_state = REFILL;
      end
      REFILL: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        lines[i].valid <= 1'b0;
        lines[i].dirty <= 1'b0;
      end
    end else if (state == IDLE && write && hit) begin
      lines[idx].data  <= put_byte(cur.data, offset, writedata);
      lines[idx].dirty <= 1'b1;
    end else if (state == REFILL) begin
      lines[miss_idx].valid <= 1'b1;
      lines[miss_idx].dirty <= 1'b0;
      lines[miss_idx].tag   <= TAG_MAX_W'(miss_tag);
      lines[miss_idx].data  <= mem_readdata;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  // The hit that completes a refilled request is the tail of a miss, not a hit.
  logic post_refill;

  always_ff @(posedge clock) begin
    if (reset) post_refill <= 1'b0;
    else       post_refill <= (state == REFILL);
  end

  data_cache_stats u_stats (
    .clock      (clock),
    .reset      (reset),
    .hit_event  (req && idle_hit && !post_refill),
    .miss_event (req && (state == IDLE) && !hit),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: miss/refill/write-back sequences, a table of
// IDLE hit vectors, reset during a miss, and (optionally) the statistics counters.
module tb_data_cache;
  import cache_pkg::*;

  logic        clock = 1'b0;
  logic        reset, read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  data_cache #(.NUM_SETS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  function automatic logic [7:0] mem_byte(input int blk, input int k);
    return 8'((blk * 4 + k) ^ 32'hC3);
  endfunction

  // Block memory: each request is busy for two cycles, then completes on the third edge.
  logic [31:0] mem [64];
  logic [1:0]  mcnt;
  logic [31:0] mem_rdata_q;

  assign mem_busywait = (mem_read || mem_write) && (mcnt != 2'd2);
  assign mem_readdata = mem_rdata_q;

  always @(posedge clock) begin
    if (reset) begin
      mcnt <= 2'd0;
      for (int i = 0; i < 64; i++)
        mem[i] <= {mem_byte(i, 3), mem_byte(i, 2), mem_byte(i, 1), mem_byte(i, 0)};
    end else if (mem_read || mem_write) begin
      if (mcnt == 2'd2) begin
        mcnt <= 2'd0;
        if (mem_write) mem[mem_address] <= mem_writedata;
        if (mem_read)  mem_rdata_q <= mem[mem_address];
      end else begin
        mcnt <= mcnt + 2'd1;
      end
    end else begin
      mcnt <= 2'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory strobes must be exclusive and quiet in IDLE/REFILL.
  always @(negedge clock) begin
    if (!reset) begin
      logic bad;
      bad = (mem_read && mem_write) ||
            ((dut.state == IDLE || dut.state == REFILL) && (mem_read || mem_write));
      chk("mem_strobes", {31'b0, bad}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input state_t s, input string name);
    int n = 0;
    while (dut.state != s && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(dut.state), 32'(s));
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output logic [7:0] rdv);
    int n = 0;
    read = rd; write = wr; address = a; writedata = wd;
    #1;
    while (busywait && n < 100) begin
      step();
      n++;
    end
    chk("access_done", {31'b0, busywait}, 32'd0);
    rdv = readdata;
    step();
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       busy;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] rv;
  logic [7:0] vbits;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, mem_byte(0, 0)};
    vecs[1]  = '{1'b1, 1'b0, 8'h03, 8'h00, 1'b0, mem_byte(0, 3)};
    vecs[2]  = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b0, mem_byte(9, 0)};
    vecs[3]  = '{1'b1, 1'b0, 8'h27, 8'h00, 1'b0, mem_byte(9, 3)};
    vecs[4]  = '{1'b0, 1'b0, 8'h24, 8'h00, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'h02, 8'h5E, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h5E};
    vecs[7]  = '{1'b1, 1'b1, 8'h01, 8'h77, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h77};
    vecs[9]  = '{1'b0, 1'b1, 8'h26, 8'h11, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 8'h11};
    vecs[11] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b0, mem_byte(9, 1)};

    read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    do_reset();

    // Reset state
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_busywait", {31'b0, busywait}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_address", {26'b0, mem_address}, 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_readdata", {24'b0, readdata}, 32'd0);

    // Cold read miss on line 0
    read = 1'b1; address = 8'h00;
    #1;
    chk("miss0_busy", {31'b0, busywait}, 32'd1);
    chk("miss0_rdata", {24'b0, readdata}, 32'd0);
    step();
    chk("miss0_state", 32'(dut.state), 32'(FETCH));
    chk("miss0_mem_read", {31'b0, mem_read}, 32'd1);
    chk("miss0_mem_addr", {26'b0, mem_address}, 32'h00);
    wait_state(REFILL, "miss0_refill");
    chk("miss0_refill_rd", {31'b0, mem_read}, 32'd0);
    step();
    chk("miss0_idle", 32'(dut.state), 32'(IDLE));
    chk("miss0_done_busy", {31'b0, busywait}, 32'd0);
    chk("miss0_rdata_hit", {24'b0, readdata}, {24'b0, mem_byte(0, 0)});
    chk("miss0_valid", {31'b0, dut.lines[0].valid}, 32'd1);
    step();
    read = 1'b0;

    // Fill line 1, then a zero-stall write hit
    access(1'b1, 1'b0, 8'h04, 8'h00, rv);
    chk("fill1_rdata", {24'b0, rv}, {24'b0, mem_byte(1, 0)});
    write = 1'b1; address = 8'h05; writedata = 8'hAB;
    #1;
    chk("wr05_busy", {31'b0, busywait}, 32'd0);
    step();
    write = 1'b0;
    chk("wr05_byte", {24'b0, dut.lines[1].data[15:8]}, 32'hAB);
    chk("wr05_dirty", {31'b0, dut.lines[1].dirty}, 32'd1);

    // Conflict miss with dirty victim
    read = 1'b1; address = 8'h25;
    #1;
    chk("rd25_busy", {31'b0, busywait}, 32'd1);
    step();
    chk("wb_state", 32'(dut.state), 32'(WRITE_BACK));
    chk("wb_mem_write", {31'b0, mem_write}, 32'd1);
    chk("wb_mem_addr", {26'b0, mem_address}, 32'h01);
    chk("wb_byte1", {24'b0, mem_writedata[15:8]}, 32'hAB);
    wait_state(FETCH, "wb_to_fetch");
    chk("fetch_mem_addr", {26'b0, mem_address}, 32'h09);
    chk("fetch_mem_read", {31'b0, mem_read}, 32'd1);
    chk("wb_landed", mem[1], {mem_byte(1, 3), mem_byte(1, 2), 8'hAB, mem_byte(1, 0)});
    wait_state(REFILL, "fetch_to_refill");
    step();
    chk("rd25_rdata", {24'b0, readdata}, {24'b0, mem_byte(9, 1)});
    chk("rd25_dirty", {31'b0, dut.lines[1].dirty}, 32'd0);
    step();
    read = 1'b0;

    // IDLE hit vectors
    for (int i = 0; i < 12; i++) begin
      read = vecs[i].rd; write = vecs[i].wr;
      address = vecs[i].addr; writedata = vecs[i].wd;
      #2;
      chk($sformatf("vec%0d_busy", i), {31'b0, busywait}, {31'b0, vecs[i].busy});
      chk($sformatf("vec%0d_rdata", i), {24'b0, readdata}, {24'b0, vecs[i].rdata});
      step();
    end
    read = 1'b0; write = 1'b0;
    chk("rw_dirty0", {31'b0, dut.lines[0].dirty}, 32'd1);
    chk("wr26_dirty1", {31'b0, dut.lines[1].dirty}, 32'd1);

    // Reset in the middle of a fetch
    read = 1'b1; address = 8'h10;
    step();
    chk("rstf_state", 32'(dut.state), 32'(FETCH));
    reset = 1'b1;
    step();
    chk("rstf_idle", 32'(dut.state), 32'(IDLE));
    chk("rstf_mem_read", {31'b0, mem_read}, 32'd0);
    for (int i = 0; i < 8; i++) vbits[i] = dut.lines[i].valid | dut.lines[i].dirty;
    chk("rstf_valid_dirty", {24'b0, vbits}, 32'd0);
    reset = 1'b0; read = 1'b0;
    read = 1'b1; address = 8'h00;
    #1;
    chk("rstf_cold_miss", {31'b0, busywait}, 32'd1);
    read = 1'b0;

    // Two misses then three hits
    do_reset();
    access(1'b1, 1'b0, 8'h00, 8'h00, rv);
    access(1'b1, 1'b0, 8'h04, 8'h00, rv);
    access(1'b1, 1'b0, 8'h01, 8'h00, rv);
    chk("seq_rd01", {24'b0, rv}, {24'b0, mem_byte(0, 1)});
    access(1'b0, 1'b1, 8'h02, 8'h3C, rv);
    access(1'b1, 1'b0, 8'h05, 8'h00, rv);
    chk("seq_rd05", {24'b0, rv}, {24'b0, mem_byte(1, 1)});
`ifdef DATA_CACHE_STATS_EN
    chk("stats_hits", {16'b0, hit_count}, 32'd3);
    chk("stats_misses", {16'b0, miss_count}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 8: number of direct-mapped 4-byte lines, a power of two from 2 to 32; index width IW = log2(NUM_SETS), tag width TW = 6 - IW.
REQ-002 The block SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port read  input  1  CPU load request, held until busywait is low.
REQ-005 The block SHALL have port write  input  1  CPU store request, held until busywait is low.
REQ-006 The block SHALL have port address  input  8  CPU byte address {tag[TW], index[IW], offset[2]}.
REQ-007 The block SHALL have port writedata  input  8  CPU store byte.
REQ-008 The block SHALL have port readdata  output  8  CPU load byte.
REQ-009 The block SHALL have port busywait  output  1  CPU stall.
REQ-010 The block SHALL have port mem_read  output  1  block read request to data memory.
REQ-011 The block SHALL have port mem_write  output  1  block write request to data memory.
REQ-012 The block SHALL have port mem_address  output  6  block address to data memory.
REQ-013 The block SHALL have port mem_writedata  output  32  write-back block, byte 0 in [7:0].
REQ-014 The block SHALL have port mem_readdata  input  32  fetched block, byte 0 in [7:0].
REQ-015 The block SHALL have port mem_busywait  input  1  data memory busy.

Function
REQ-016 Per line: valid bit, dirty bit, TW-bit tag, 32-bit data; hit = valid && stored tag == address tag at address index.
REQ-017 FSM states: IDLE, WRITE_BACK, FETCH, REFILL.
REQ-018 busywait SHALL be combinational: (read || write) && !(state == IDLE && hit).
REQ-019 Read hit in IDLE: readdata = selected byte, combinational, same cycle; no state change.
REQ-020 Write hit in IDLE: at the rising edge, the selected byte takes writedata and dirty is set; zero stall cycles.
REQ-021 read && write both high: treat as write; read ignored.
REQ-022 IDLE, request, miss, victim dirty -> WRITE_BACK; victim clean or invalid -> FETCH.
REQ-023 WRITE_BACK: mem_write=1, mem_address={victim tag, index}, mem_writedata=victim data; -> FETCH on the edge where mem_busywait=0, with at least one cycle spent in the state.
REQ-024 FETCH: mem_read=1, mem_address={address tag, index}; -> REFILL on the edge where mem_busywait=0, with at least one cycle spent in the state.
REQ-025 REFILL: mem_read=mem_write=0; at the edge, line data=mem_readdata, tag updated, valid=1, dirty=0; -> IDLE, where the held request then completes as a hit.
REQ-026 mem_read and mem_write SHALL never be high together, and SHALL be 0 in IDLE and REFILL.
REQ-027 readdata SHALL be 0 when there is no read hit.
REQ-028 CPU address and request changes outside IDLE are ignored; the CPU holds them while busywait is high.

Reset
REQ-029 On reset at a rising edge: state=IDLE, all valid and dirty bits=0, mem_read=mem_write=0, mem_address=0, mem_writedata=0, readdata=0; any miss in flight is abandoned.
REQ-030 Reset SHALL take priority over every other event in the same cycle; tags and data need not be cleared.

Configuration
REQ-031 With DATA_CACHE_STATS_EN defined, the block SHALL add outputs hit_count[15:0] and miss_count[15:0], each reset to 0 and saturating at 0xFFFF.
REQ-032 With DATA_CACHE_STATS_EN defined, hit_count SHALL increment once per completed first-attempt hit and miss_count once per IDLE miss detection; a post-refill completion SHALL not count as a hit.
REQ-033 Without DATA_CACHE_STATS_EN, these ports and their logic SHALL be absent.

Structure
REQ-034 Package cache_pkg SHALL hold the FSM state enum, BLOCK_BYTES=4, MEM_ADDR_W=6 and the line-entry struct {valid, dirty, tag, data}.
REQ-035 The statistics counters SHALL be in sub-module data_cache_stats, instantiated only under DATA_CACHE_STATS_EN.

Verification
REQ-036 After reset, read 0x00 -> busywait high, FETCH with mem_address=0x00, then REFILL, then readdata = memory byte 0, valid[0]=1.
REQ-037 Write 0xAB to 0x05 after line 1 has been fetched -> no stall, byte 1 of line 1 = 0xAB, dirty[1]=1.
REQ-038 Then read 0x25 (same index 1, different tag) -> WRITE_BACK at mem_address=0x01 with mem_writedata[15:8]=0xAB, then FETCH at mem_address=0x09, then REFILL.
REQ-039 Assert reset during FETCH -> next cycle state=IDLE, mem_read=0, all valid bits 0.
REQ-040 Assert read=1 and write=1 to a hit address -> write performed, line marked dirty.
REQ-041 With DATA_CACHE_STATS_EN defined, run 3 hits and 2 misses -> hit_count=3, miss_count=2.
